// File: rtl/mc_control_pkg.sv
// mc_control_pkg: shared constants and types for the multi-cycle control unit.
//   - MIPS opcode / funct encodings for the supported subset
//   - ALU_func codes driven to the datapath ALU
//   - controller state encoding and decoded instruction class
package mc_control_pkg;

  localparam logic [5:0] OpRtype = 6'b000000;
  localparam logic [5:0] OpAddi  = 6'b001000;
  localparam logic [5:0] OpLw    = 6'b100011;
  localparam logic [5:0] OpSw    = 6'b101011;
  localparam logic [5:0] OpBeq   = 6'b000100;
  localparam logic [5:0] OpBne   = 6'b000101;

  localparam logic [5:0] FnAdd = 6'b100000;
  localparam logic [5:0] FnSub = 6'b100010;
  localparam logic [5:0] FnAnd = 6'b100100;
  localparam logic [5:0] FnOr  = 6'b100101;
  localparam logic [5:0] FnSlt = 6'b101010;

  localparam logic [3:0] AluAdd = 4'b0000;
  localparam logic [3:0] AluSub = 4'b0001;
  localparam logic [3:0] AluAnd = 4'b0010;
  localparam logic [3:0] AluOr  = 4'b0011;
  localparam logic [3:0] AluSlt = 4'b0100;

  typedef enum logic [2:0] {StFetch, StDecode, StExec, StMem, StWb} state_e;

  typedef enum logic [2:0] {
    ClsRtype, ClsAddi, ClsLw, ClsSw, ClsBeq, ClsBne, ClsIllegal
  } instr_class_e;

  function automatic logic [31:0] sign_ext16(logic [15:0] imm);
    return {{16{imm[15]}}, imm};
  endfunction

endpackage

// File: rtl/mc_control_if.sv
// mc_control_if: bundle between the control unit and the fetch stage / datapath.
//   master: the controller (drives PC and datapath strobes, receives Instr and Zero)
//   slave : the fetch stage and datapath side
interface mc_control_if;
  logic [31:0] Instr;
  logic        Zero;
  logic        PC_sel;
  logic        PC_LdEn;
  logic [31:0] PC_Immed;
  logic [31:0] IR_out;
  logic        RF_WrEn;
  logic        RF_Wrdst_sel;
  logic        RF_WrData_sel;
  logic        ALU_Bin_sel;
  logic [3:0]  ALU_func;
  logic        MEM_WrEn;
  logic        Illegal;

  modport master (
    input  Instr, Zero,
    output PC_sel, PC_LdEn, PC_Immed, IR_out, RF_WrEn, RF_Wrdst_sel, RF_WrData_sel,
           ALU_Bin_sel, ALU_func, MEM_WrEn, Illegal
  );

  modport slave (
    output Instr, Zero,
    input  PC_sel, PC_LdEn, PC_Immed, IR_out, RF_WrEn, RF_Wrdst_sel, RF_WrData_sel,
           ALU_Bin_sel, ALU_func, MEM_WrEn, Illegal
  );
endinterface

// File: rtl/mc_control_instr_decode.sv
// mc_control_instr_decode: purely combinational instruction decoder.
//   opcode_i   : IR[31:26]
//   funct_i    : IR[5:0]
//   cls_o      : instruction class (ClsIllegal for anything unsupported)
//   alu_func_o : ALU operation the instruction needs in EXEC
module mc_control_instr_decode
  import mc_control_pkg::*;
(
  input  logic [5:0]   opcode_i,
  input  logic [5:0]   funct_i,
  output instr_class_e cls_o,
  output logic [3:0]   alu_func_o
);

  always_comb begin
    cls_o      = ClsIllegal;
    alu_func_o = AluAdd;
    case (opcode_i)
      OpRtype: begin
        case (funct_i)
          FnAdd: begin cls_o = ClsRtype; alu_func_o = AluAdd; end
          FnSub: begin cls_o = ClsRtype; alu_func_o = AluSub; end
          FnAnd: begin cls_o = ClsRtype; alu_func_o = AluAnd; end
          FnOr:  begin cls_o = ClsRtype; alu_func_o = AluOr;  end
          FnSlt: begin cls_o = ClsRtype; alu_func_o = AluSlt; end
          default: ;
        endcase
      end
      OpAddi: cls_o = ClsAddi;
      OpLw:   cls_o = ClsLw;
      OpSw:   cls_o = ClsSw;
      OpBeq:  begin cls_o = ClsBeq; alu_func_o = AluSub; end
      OpBne:  begin cls_o = ClsBne; alu_func_o = AluSub; end
      default: ;
    endcase
  end

endmodule

// File: rtl/mc_control.sv
// mc_control: multi-cycle control FSM (FETCH, DECODE, EXEC, MEM, WB).
//   Clk   : rising-edge clock
//   Reset : synchronous active-high reset; also masks all strobes in the same cycle
//   bus   : master side of mc_control_if (Instr/Zero in, PC and datapath controls out)
// ROM_LAT sets the FETCH length and MEM_LAT the MEM length; both share one down-counter.
module mc_control
  import mc_control_pkg::*;
#(
  parameter int unsigned ROM_LAT = 1,
  parameter int unsigned MEM_LAT = 1
) (
  input  logic Clk,
  input  logic Reset,
  mc_control_if.master bus
);

  localparam int unsigned MaxLat = (ROM_LAT > MEM_LAT) ? ROM_LAT : MEM_LAT;
  localparam int unsigned CntW   = $clog2(MaxLat + 1);
  localparam logic [CntW-1:0] RomReload = CntW'(ROM_LAT - 1);
  localparam logic [CntW-1:0] MemReload = CntW'(MEM_LAT - 1);

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [31:0]     ir_q, ir_d;
  logic            illegal_q, illegal_d;

  instr_class_e cls;
  logic [3:0]   dec_alu_func;
  logic         pc_ld, pc_sel, rf_wr, mem_wr;

  mc_control_instr_decode u_decode (
    .opcode_i   (ir_q[31:26]),
    .funct_i    (ir_q[5:0]),
    .cls_o      (cls),
    .alu_func_o (dec_alu_func)
  );

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q   <= StFetch;
      cnt_q     <= RomReload;
      ir_q      <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      ir_q      <= ir_d;
      illegal_q <= illegal_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    ir_d      = ir_q;
    illegal_d = illegal_q;
    pc_ld     = 1'b0;
    pc_sel    = 1'b0;
    rf_wr     = 1'b0;
    mem_wr    = 1'b0;

    unique case (state_q)
      StFetch: begin
        if (cnt_q == '0) begin
          ir_d    = bus.Instr;
          state_d = StDecode;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      StDecode: begin
        if (cls == ClsIllegal) begin
          // Retire as a NOP: advance PC by 4 and flag it.
          illegal_d = 1'b1;
          pc_ld     = 1'b1;
          state_d   = StFetch;
          cnt_d     = RomReload;
        end else begin
          state_d = StExec;
        end
      end
      StExec: begin
        case (cls)
          ClsRtype, ClsAddi: state_d = StWb;
          ClsLw, ClsSw: begin
            state_d = StMem;
            cnt_d   = MemReload;
          end
          ClsBeq, ClsBne: begin
            pc_ld   = 1'b1;
            pc_sel  = (cls == ClsBeq) ? bus.Zero : ~bus.Zero;
            state_d = StFetch;
            cnt_d   = RomReload;
          end
          default: begin
            // Unreachable (illegal never leaves DECODE); keep the one-PC-load invariant.
            pc_ld   = 1'b1;
            state_d = StFetch;
            cnt_d   = RomReload;
          end
        endcase
      end
      StMem: begin
        // First MEM cycle is when the counter still holds its reload value.
        mem_wr = (cls == ClsSw) && (cnt_q == MemReload);
        if (cnt_q == '0) begin
          if (cls == ClsSw) begin
            pc_ld   = 1'b1;
            state_d = StFetch;
            cnt_d   = RomReload;
          end else begin
            state_d = StWb;
          end
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      StWb: begin
        rf_wr   = 1'b1;
        pc_ld   = 1'b1;
        state_d = StFetch;
        cnt_d   = RomReload;
      end
      default: begin
        state_d = StFetch;
        cnt_d   = RomReload;
      end
    endcase

    // Reset aborts the instruction: no partial register, memory or PC update.
    if (Reset) begin
      pc_ld  = 1'b0;
      rf_wr  = 1'b0;
      mem_wr = 1'b0;
    end
  end

  assign bus.PC_sel        = pc_sel;
  assign bus.PC_LdEn       = pc_ld;
  assign bus.PC_Immed      = sign_ext16(ir_q[15:0]);
  assign bus.IR_out        = ir_q;
  assign bus.RF_WrEn       = rf_wr;
  assign bus.RF_Wrdst_sel  = (cls == ClsRtype);
  assign bus.RF_WrData_sel = (cls == ClsLw);
  assign bus.ALU_Bin_sel   = (cls == ClsAddi) || (cls == ClsLw) || (cls == ClsSw);
  assign bus.ALU_func      = dec_alu_func;
  assign bus.MEM_WrEn      = mem_wr;
  assign bus.Illegal       = illegal_q;

endmodule

// File: tb/tb_mc_control.sv
// tb_mc_control: directed self-checking bench for mc_control.
// u_dut_a uses ROM_LAT=MEM_LAT=1, u_dut_b uses ROM_LAT=1, MEM_LAT=3; both share Clk/Reset
// and see the same Instr/Zero. Outputs are sampled on the falling edge.
module tb_mc_control;

  logic Clk = 1'b0;
  logic Reset = 1'b1;
  int   checks = 0;
  int   errors = 0;

  mc_control_if bus_a ();
  mc_control_if bus_b ();

  mc_control #(.ROM_LAT(1), .MEM_LAT(1)) u_dut_a (.Clk(Clk), .Reset(Reset), .bus(bus_a));
  mc_control #(.ROM_LAT(1), .MEM_LAT(3)) u_dut_b (.Clk(Clk), .Reset(Reset), .bus(bus_b));

  always #5 Clk = ~Clk;

  task automatic next_cyc();
    @(negedge Clk);
  endtask

  task automatic set_in(input logic [31:0] instr, input logic z);
    bus_a.Instr = instr;
    bus_b.Instr = instr;
    bus_a.Zero  = z;
    bus_b.Zero  = z;
  endtask

  // Leaves both DUTs in FETCH at a falling edge with Reset low.
  task automatic do_reset();
    Reset = 1'b1;
    set_in(32'h0, 1'b0);
    repeat (2) @(negedge Clk);
    Reset = 1'b0;
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    set_in(32'h0, 1'b0);
    @(negedge Clk);
    checks++; if (bus_a.PC_LdEn !== 1'b0) begin errors++; $display("FAIL rst_pcld got %b exp 0", bus_a.PC_LdEn); end
    checks++; if (bus_a.RF_WrEn !== 1'b0) begin errors++; $display("FAIL rst_rfwr got %b exp 0", bus_a.RF_WrEn); end
    checks++; if (bus_a.MEM_WrEn !== 1'b0) begin errors++; $display("FAIL rst_memwr got %b exp 0", bus_a.MEM_WrEn); end
    checks++; if (bus_a.IR_out !== 32'h0) begin errors++; $display("FAIL rst_ir got %h exp 0", bus_a.IR_out); end
    checks++; if (bus_a.Illegal !== 1'b0) begin errors++; $display("FAIL rst_illegal got %b exp 0", bus_a.Illegal); end
    checks++; if (bus_b.IR_out !== 32'h0) begin errors++; $display("FAIL rst_ir_b got %h exp 0", bus_b.IR_out); end
    @(negedge Clk);
    Reset = 1'b0;
    #1;
    checks++; if (bus_a.PC_LdEn !== 1'b0) begin errors++; $display("FAIL rst_fetch_pcld got %b exp 0", bus_a.PC_LdEn); end
  endtask

  task automatic test_add();
    do_reset();
    set_in(32'h00432020, 1'b0);
    #1;
    checks++; if (bus_a.PC_LdEn !== 1'b0) begin errors++; $display("FAIL add_f_pcld got %b exp 0", bus_a.PC_LdEn); end
    next_cyc(); // DECODE
    checks++; if (bus_a.IR_out !== 32'h00432020) begin errors++; $display("FAIL add_d_ir got %h exp 00432020", bus_a.IR_out); end
    checks++; if (bus_a.PC_LdEn !== 1'b0) begin errors++; $display("FAIL add_d_pcld got %b exp 0", bus_a.PC_LdEn); end
    checks++; if (bus_a.PC_Immed !== 32'h00002020) begin errors++; $display("FAIL add_d_imm got %h exp 00002020", bus_a.PC_Immed); end
    next_cyc(); // EXEC
    checks++; if (bus_a.ALU_func !== 4'b0000) begin errors++; $display("FAIL add_e_alu got %b exp 0000", bus_a.ALU_func); end
    checks++; if (bus_a.ALU_Bin_sel !== 1'b0) begin errors++; $display("FAIL add_e_bsel got %b exp 0", bus_a.ALU_Bin_sel); end
    checks++; if (bus_a.PC_LdEn !== 1'b0) begin errors++; $display("FAIL add_e_pcld got %b exp 0", bus_a.PC_LdEn); end
    checks++; if (bus_a.RF_WrEn !== 1'b0) begin errors++; $display("FAIL add_e_rfwr got %b exp 0", bus_a.RF_WrEn); end
    next_cyc(); // WB
    checks++; if (bus_a.RF_WrEn !== 1'b1) begin errors++; $display("FAIL add_w_rfwr got %b exp 1", bus_a.RF_WrEn); end
    checks++; if (bus_a.RF_Wrdst_sel !== 1'b1) begin errors++; $display("FAIL add_w_dst got %b exp 1", bus_a.RF_Wrdst_sel); end
    checks++; if (bus_a.RF_WrData_sel !== 1'b0) begin errors++; $display("FAIL add_w_wdsel got %b exp 0", bus_a.RF_WrData_sel); end
    checks++; if (bus_a.PC_LdEn !== 1'b1) begin errors++; $display("FAIL add_w_pcld got %b exp 1", bus_a.PC_LdEn); end
    checks++; if (bus_a.PC_sel !== 1'b0) begin errors++; $display("FAIL add_w_pcsel got %b exp 0", bus_a.PC_sel); end
    next_cyc(); // FETCH
    checks++; if (bus_a.PC_LdEn !== 1'b0) begin errors++; $display("FAIL add_f2_pcld got %b exp 0", bus_a.PC_LdEn); end
    checks++; if (bus_a.RF_WrEn !== 1'b0) begin errors++; $display("FAIL add_f2_rfwr got %b exp 0", bus_a.RF_WrEn); end
  endtask

  task automatic test_alu_funcs();
    logic [31:0] instr_t [5] = '{32'h00432022, 32'h00432024, 32'h00432025, 32'h0043202A,
                                 32'h20450007};
    logic [3:0]  alu_t [5]   = '{4'b0001, 4'b0010, 4'b0011, 4'b0100, 4'b0000};
    logic        bsel_t [5]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    logic        dst_t [5]   = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    do_reset();
    for (int k = 0; k < 5; k++) begin
      set_in(instr_t[k], 1'b0);
      next_cyc(); // DECODE
      next_cyc(); // EXEC
      checks++; if (bus_a.ALU_func !== alu_t[k]) begin errors++; $display("FAIL alu_func[%0d] got %b exp %b", k, bus_a.ALU_func, alu_t[k]); end
      checks++; if (bus_a.ALU_Bin_sel !== bsel_t[k]) begin errors++; $display("FAIL alu_bsel[%0d] got %b exp %b", k, bus_a.ALU_Bin_sel, bsel_t[k]); end
      next_cyc(); // WB
      checks++; if (bus_a.RF_Wrdst_sel !== dst_t[k]) begin errors++; $display("FAIL alu_dst[%0d] got %b exp %b", k, bus_a.RF_Wrdst_sel, dst_t[k]); end
      checks++; if (bus_a.RF_WrEn !== 1'b1) begin errors++; $display("FAIL alu_rfwr[%0d] got %b exp 1", k, bus_a.RF_WrEn); end
      next_cyc(); // FETCH
    end
  endtask

  task automatic test_lw();
    logic exp_end;
    do_reset();
    set_in(32'h8C450008, 1'b0);
    for (int i = 0; i <= 6; i++) begin
      if (i > 0) next_cyc(); else #1;
      exp_end = (i == 6);
      checks++; if (bus_b.RF_WrEn !== exp_end) begin errors++; $display("FAIL lw_rfwr@%0d got %b exp %b", i, bus_b.RF_WrEn, exp_end); end
      checks++; if (bus_b.PC_LdEn !== exp_end) begin errors++; $display("FAIL lw_pcld@%0d got %b exp %b", i, bus_b.PC_LdEn, exp_end); end
      checks++; if (bus_b.MEM_WrEn !== 1'b0) begin errors++; $display("FAIL lw_memwr@%0d got %b exp 0", i, bus_b.MEM_WrEn); end
      if (i == 1) begin
        checks++; if (bus_b.PC_Immed !== 32'h00000008) begin errors++; $display("FAIL lw_imm got %h exp 00000008", bus_b.PC_Immed); end
      end
      if (i == 2) begin
        checks++; if (bus_b.ALU_func !== 4'b0000) begin errors++; $display("FAIL lw_alu got %b exp 0000", bus_b.ALU_func); end
        checks++; if (bus_b.ALU_Bin_sel !== 1'b1) begin errors++; $display("FAIL lw_bsel got %b exp 1", bus_b.ALU_Bin_sel); end
      end
      if (i == 6) begin
        checks++; if (bus_b.RF_WrData_sel !== 1'b1) begin errors++; $display("FAIL lw_wdsel got %b exp 1", bus_b.RF_WrData_sel); end
        checks++; if (bus_b.RF_Wrdst_sel !== 1'b0) begin errors++; $display("FAIL lw_dst got %b exp 0", bus_b.RF_Wrdst_sel); end
      end
    end
    next_cyc();
    checks++; if (bus_b.PC_LdEn !== 1'b0) begin errors++; $display("FAIL lw_next_pcld got %b exp 0", bus_b.PC_LdEn); end
  endtask

  task automatic test_sw();
    logic exp_mw, exp_ld;
    do_reset();
    set_in(32'hAC450004, 1'b0);
    for (int i = 0; i <= 6; i++) begin
      if (i > 0) next_cyc(); else #1;
      // MEM_LAT=1: single MEM cycle at 3 carries both strobes.
      if (i <= 4) begin
        exp_mw = (i == 3);
        checks++; if (bus_a.MEM_WrEn !== exp_mw) begin errors++; $display("FAIL sw1_memwr@%0d got %b exp %b", i, bus_a.MEM_WrEn, exp_mw); end
        checks++; if (bus_a.PC_LdEn !== exp_mw) begin errors++; $display("FAIL sw1_pcld@%0d got %b exp %b", i, bus_a.PC_LdEn, exp_mw); end
        checks++; if (bus_a.RF_WrEn !== 1'b0) begin errors++; $display("FAIL sw1_rfwr@%0d got %b exp 0", i, bus_a.RF_WrEn); end
      end
      if (i == 1) begin
        checks++; if (bus_a.PC_Immed !== 32'h00000004) begin errors++; $display("FAIL sw1_imm got %h exp 00000004", bus_a.PC_Immed); end
      end
      // MEM_LAT=3: write in first MEM cycle (3), PC load in last (5).
      exp_mw = (i == 3);
      exp_ld = (i == 5);
      checks++; if (bus_b.MEM_WrEn !== exp_mw) begin errors++; $display("FAIL sw3_memwr@%0d got %b exp %b", i, bus_b.MEM_WrEn, exp_mw); end
      checks++; if (bus_b.PC_LdEn !== exp_ld) begin errors++; $display("FAIL sw3_pcld@%0d got %b exp %b", i, bus_b.PC_LdEn, exp_ld); end
      checks++; if (bus_b.RF_WrEn !== 1'b0) begin errors++; $display("FAIL sw3_rfwr@%0d got %b exp 0", i, bus_b.RF_WrEn); end
    end
  endtask

  // Entered at a falling edge in FETCH of u_dut_a; returns in the following FETCH.
  task automatic test_branch_case(input logic [31:0] instr, input logic z, input logic exp_sel);
    set_in(instr, z);
    next_cyc(); // DECODE
    checks++; if (bus_a.PC_LdEn !== 1'b0) begin errors++; $display("FAIL br_d_pcld %h got %b exp 0", instr, bus_a.PC_LdEn); end
    next_cyc(); // EXEC
    checks++; if (bus_a.PC_LdEn !== 1'b1) begin errors++; $display("FAIL br_e_pcld %h got %b exp 1", instr, bus_a.PC_LdEn); end
    checks++; if (bus_a.PC_sel !== exp_sel) begin errors++; $display("FAIL br_e_pcsel %h z=%b got %b exp %b", instr, z, bus_a.PC_sel, exp_sel); end
    checks++; if (bus_a.PC_Immed !== 32'hFFFFFFFC) begin errors++; $display("FAIL br_e_imm %h got %h exp FFFFFFFC", instr, bus_a.PC_Immed); end
    checks++; if (bus_a.ALU_func !== 4'b0001) begin errors++; $display("FAIL br_e_alu %h got %b exp 0001", instr, bus_a.ALU_func); end
    checks++; if (bus_a.ALU_Bin_sel !== 1'b0) begin errors++; $display("FAIL br_e_bsel %h got %b exp 0", instr, bus_a.ALU_Bin_sel); end
    // PC_sel must follow Zero combinationally within EXEC.
    bus_a.Zero = ~z;
    #1;
    checks++; if (bus_a.PC_sel !== ~exp_sel) begin errors++; $display("FAIL br_e_zflip %h got %b exp %b", instr, bus_a.PC_sel, ~exp_sel); end
    bus_a.Zero = z;
    next_cyc(); // FETCH
    checks++; if (bus_a.PC_LdEn !== 1'b0) begin errors++; $display("FAIL br_f_pcld %h got %b exp 0", instr, bus_a.PC_LdEn); end
  endtask

  task automatic test_branch();
    do_reset();
    test_branch_case(32'h1022FFFC, 1'b1, 1'b1);
    test_branch_case(32'h1022FFFC, 1'b0, 1'b0);
    test_branch_case(32'h1422FFFC, 1'b0, 1'b1);
    test_branch_case(32'h1422FFFC, 1'b1, 1'b0);
  endtask

  task automatic test_illegal();
    do_reset();
    set_in(32'hFC000000, 1'b0);
    next_cyc(); // DECODE
    checks++; if (bus_a.PC_LdEn !== 1'b1) begin errors++; $display("FAIL ill1_pcld got %b exp 1", bus_a.PC_LdEn); end
    checks++; if (bus_a.PC_sel !== 1'b0) begin errors++; $display("FAIL ill1_pcsel got %b exp 0", bus_a.PC_sel); end
    checks++; if (bus_a.Illegal !== 1'b0) begin errors++; $display("FAIL ill1_early got %b exp 0", bus_a.Illegal); end
    checks++; if (bus_a.RF_WrEn !== 1'b0) begin errors++; $display("FAIL ill1_rfwr got %b exp 0", bus_a.RF_WrEn); end
    next_cyc(); // FETCH
    checks++; if (bus_a.Illegal !== 1'b1) begin errors++; $display("FAIL ill1_flag got %b exp 1", bus_a.Illegal); end
    checks++; if (bus_a.PC_LdEn !== 1'b0) begin errors++; $display("FAIL ill1_f_pcld got %b exp 0", bus_a.PC_LdEn); end
    set_in(32'h00000003, 1'b0);
    next_cyc(); // DECODE
    checks++; if (bus_a.PC_LdEn !== 1'b1) begin errors++; $display("FAIL ill2_pcld got %b exp 1", bus_a.PC_LdEn); end
    checks++; if (bus_a.PC_sel !== 1'b0) begin errors++; $display("FAIL ill2_pcsel got %b exp 0", bus_a.PC_sel); end
    next_cyc(); // FETCH
    set_in(32'h00432020, 1'b0);
    next_cyc(); // DECODE
    checks++; if (bus_a.PC_LdEn !== 1'b0) begin errors++; $display("FAIL ill_add_d_pcld got %b exp 0", bus_a.PC_LdEn); end
    next_cyc(); // EXEC
    next_cyc(); // WB
    checks++; if (bus_a.RF_WrEn !== 1'b1) begin errors++; $display("FAIL ill_add_rfwr got %b exp 1", bus_a.RF_WrEn); end
    next_cyc(); // FETCH
    checks++; if (bus_a.Illegal !== 1'b1) begin errors++; $display("FAIL ill_sticky got %b exp 1", bus_a.Illegal); end
  endtask

  task automatic test_reset_mid_wb();
    do_reset();
    set_in(32'hFC000000, 1'b0);
    next_cyc(); // DECODE (illegal)
    next_cyc(); // FETCH
    set_in(32'h00432020, 1'b0);
    next_cyc(); // DECODE
    next_cyc(); // EXEC
    next_cyc(); // WB
    checks++; if (bus_a.RF_WrEn !== 1'b1) begin errors++; $display("FAIL rwb_pre_rfwr got %b exp 1", bus_a.RF_WrEn); end
    Reset = 1'b1;
    #1;
    for (int i = 0; i < 3; i++) begin
      if (i > 0) next_cyc();
      checks++; if (bus_a.RF_WrEn !== 1'b0) begin errors++; $display("FAIL rwb_rfwr@%0d got %b exp 0", i, bus_a.RF_WrEn); end
      checks++; if (bus_a.PC_LdEn !== 1'b0) begin errors++; $display("FAIL rwb_pcld@%0d got %b exp 0", i, bus_a.PC_LdEn); end
    end
    next_cyc();
    Reset = 1'b0;
    #1;
    checks++; if (bus_a.IR_out !== 32'h0) begin errors++; $display("FAIL rwb_ir got %h exp 0", bus_a.IR_out); end
    checks++; if (bus_a.Illegal !== 1'b0) begin errors++; $display("FAIL rwb_illegal got %b exp 0", bus_a.Illegal); end
    checks++; if (bus_a.PC_LdEn !== 1'b0) begin errors++; $display("FAIL rwb_f_pcld got %b exp 0", bus_a.PC_LdEn); end
    next_cyc(); // DECODE of the add fetched after release
    checks++; if (bus_a.IR_out !== 32'h00432020) begin errors++; $display("FAIL rwb_refetch got %h exp 00432020", bus_a.IR_out); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_add();
    test_alu_funcs();
    test_lw();
    test_sw();
    test_branch();
    test_illegal();
    test_reset_mid_wb();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mc_control.md
Name: mc_control

Overview:
- Multi-cycle control FSM that drives the fetch stage and consumes the fetched instruction.
- Outputs PC_sel, PC_LdEn and PC_Immed into the fetch stage, and receives Instr from the synchronous instruction ROM.
- Latches Instr into an internal IR, decodes a MIPS subset, and sequences register-file, ALU and data-memory strobes.
- Datapath flags (Zero) feed back into it.

Parameters:
- ROM_LAT, 1, cycles from a PC update to a valid Instr (>=1).
- MEM_LAT, 1, cycles a data-memory access occupies (>=1).

Ports:
- Clk  in  1  system clock, rising edge.
- Reset  in  1  synchronous, active-high.
- Instr  in  32  instruction word from the instruction ROM.
- Zero  in  1  ALU result == 0; valid combinationally in EXEC.
- PC_sel  out  1  0 = PC+4, 1 = PC+4+(PC_Immed<<2).
- PC_LdEn  out  1  one-cycle PC load strobe.
- PC_Immed  out  32  sign-extended IR[15:0], unshifted.
- IR_out  out  32  latched instruction for the datapath.
- RF_WrEn  out  1  register-file write strobe.
- RF_Wrdst_sel  out  1  0 = rt (IR[20:16]), 1 = rd (IR[15:11]).
- RF_WrData_sel  out  1  0 = ALU result, 1 = memory data.
- ALU_Bin_sel  out  1  0 = register B, 1 = PC_Immed.
- ALU_func  out  4  ADD=0000, SUB=0001, AND=0010, OR=0011, SLT=0100.
- MEM_WrEn  out  1  data-memory write strobe.
- Illegal  out  1  sticky flag, set on an undecodable instruction.

Behaviour:
- Reset (synchronous, active-high): next state FETCH, wait counter = ROM_LAT-1, IR = 0, Illegal = 0.
  - While Reset is high, all strobes (PC_LdEn, RF_WrEn, MEM_WrEn) are forced 0 in that same cycle, whatever the state.
  - Reset mid-instruction aborts the instruction with no partial write; the PC itself is reset by the pc module.
- States: FETCH, DECODE, EXEC, MEM, WB. Outputs are a Moore decode of state+IR, except PC_sel in EXEC for branches (a function of Zero).
- FETCH:
  - Counter decrements each cycle.
  - On the cycle it reads 0: IR <= Instr, go to DECODE.
  - Total FETCH length = ROM_LAT cycles.
- Opcode decode, IR[31:26]:
  - 000000 = R-type, funct 100000 add / 100010 sub / 100100 and / 100101 or / 101010 slt.
  - 001000 = addi, 100011 = lw, 101011 = sw, 000100 = beq, 000101 = bne.
  - Anything else, including an unknown funct, is illegal.
- DECODE (1 cycle):
  - PC_Immed is valid from this cycle until the next FETCH.
  - Legal instruction: go to EXEC.
  - Illegal instruction: set Illegal, PC_LdEn=1, PC_sel=0 (treated as a NOP), go to FETCH.
- EXEC (1 cycle):
  - R-type: ALU_func from funct, ALU_Bin_sel=0. Go to WB.
  - addi, lw, sw: ADD, ALU_Bin_sel=1. addi goes to WB; lw and sw go to MEM.
  - beq/bne: SUB, ALU_Bin_sel=0, PC_LdEn=1. PC_sel=Zero for beq, ~Zero for bne. Go to FETCH.
- MEM: lasts MEM_LAT cycles, using the shared counter.
  - sw: MEM_WrEn=1 in the first MEM cycle only; PC_LdEn=1, PC_sel=0 in the last MEM cycle; then go to FETCH.
  - When MEM_LAT=1, the single MEM cycle carries both MEM_WrEn and PC_LdEn.
  - lw: no strobes; go to WB.
- WB (1 cycle): RF_WrEn=1, PC_LdEn=1, PC_sel=0, then go to FETCH.
  - RF_Wrdst_sel=1 for R-type only.
  - RF_WrData_sel=1 for lw only.
- Invariant: exactly one PC_LdEn pulse per instruction, in its final cycle.
- CPI with ROM_LAT=MEM_LAT=1: R/addi 4, lw 5, sw 4, branch 3, illegal 2.
- Counter width: clog2(max(ROM_LAT, MEM_LAT)+1). Counter reloads on every FETCH and MEM entry.
- Illegal clears only on Reset.
- Outputs are held stable within a state; no output is glitch-sensitive except PC_sel via Zero.

Decomposition:
- Package ctrl_pkg holds the opcode and funct constants, the ALU_func codes and the state encoding.
- One combinational sub-module, instr_decode: IR -> instruction class {RTYPE, ADDI, LW, SW, BEQ, BNE, ILLEGAL} plus ALU_func.

Test Plan:
- Reset held 3 cycles in the middle of WB of an add -> RF_WrEn=0 and PC_LdEn=0 throughout; after release, FETCH with IR=0 and Illegal=0.
- Instr=0x00432020 (add $4,$2,$3), ROM_LAT=1 -> DECODE@1, EXEC@2 with ALU_func=0000 and ALU_Bin_sel=0, WB@3 with RF_WrEn=1, Rf_Wrdst_sel=1, PC_LdEn=1, PC_sel=0.
- Instr=0x8C450008 (lw) with MEM_LAT=3 -> PC_Immed=0x00000008; EXEC ADD with ALU_Bin_sel=1; 3 MEM cycles; WB with RF_WrData_sel=1 and RF_WrEn=1; 7 cycles total.
- Instr=0x1022FFFC (beq, offset -4):
  - Zero=1 -> EXEC PC_LdEn=1, PC_sel=1, PC_Immed=0xFFFFFFFC.
  - Repeat with Zero=0 -> PC_sel=0.
  - bne 0x1422FFFC with Zero=0 -> PC_sel=1.
- Instr=0xAC450004 (sw), MEM_LAT=1 -> the single MEM cycle has MEM_WrEn=1 and PC_LdEn=1, and there is no RF_WrEn at any point.
- Instr=0xFC000000, then 0x00000003 (bad funct) -> Illegal=1 from the cycle after the first DECODE; each takes 2 cycles with PC_LdEn=1 and PC_sel=0; Illegal stays 1 across a later legal add.
